// File: rtl/multiword_add_ctrl_if.sv
// Request/response channels of the multi-word add/subtract sequencer.
// The slave modport is the sequencer side; the master modport is the requester/consumer side.
interface multiword_add_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             req_valid_i;
  logic             req_ready_o;
  logic [WIDTH-1:0] operand1_i;
  logic [WIDTH-1:0] operand2_i;
  logic             sub_i;
  logic             carry_i;
  logic             rsp_valid_o;
  logic             rsp_ready_i;
  logic [WIDTH-1:0] sum_o;
  logic             carry_o;
  logic             overflow_o;

  modport slave (
    input  req_valid_i, operand1_i, operand2_i, sub_i, carry_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, sum_o, carry_o, overflow_o
  );

  modport master (
    output req_valid_i, operand1_i, operand2_i, sub_i, carry_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, sum_o, carry_o, overflow_o
  );
endinterface

// File: rtl/multiword_add_ctrl.sv
// WIDTH-bit add/subtract sequencer that time-shares one external combinational 8-bit
// adder slice, one byte per cycle LSB first, rippling the carry through a register.
module multiword_add_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  multiword_add_ctrl_if.slave bus,
  output logic [7:0]          slice_op1_o,
  output logic [7:0]          slice_op2_o,
  output logic                slice_carry_o,
  input  logic [7:0]          slice_sum_i,
  input  logic                slice_carry_i,
  output logic                busy_o
);

  localparam int NBYTES = WIDTH / 8;
  localparam int IDXW   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDXW-1:0] LASTIDX = IDXW'(NBYTES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] op1_q, op1_d;
  logic [WIDTH-1:0] op2_q, op2_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [IDXW-1:0]  byteIdx_q, byteIdx_d;
  logic             carry_q, carry_d;
  logic             carryFlag_q, carryFlag_d;
  logic             ovfFlag_q, ovfFlag_d;

  logic             reqReady;
  logic             rspValid;
  logic [7:0]       sliceOp1;
  logic [7:0]       sliceOp2;
  logic             sliceCarry;
  logic [IDXW+2:0]  bitBase;

  assign bitBase = {byteIdx_q, 3'b000};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      op1_q       <= '0;
      op2_q       <= '0;
      sum_q       <= '0;
      byteIdx_q   <= '0;
      carry_q     <= 1'b0;
      carryFlag_q <= 1'b0;
      ovfFlag_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      sum_q       <= sum_d;
      byteIdx_q   <= byteIdx_d;
      carry_q     <= carry_d;
      carryFlag_q <= carryFlag_d;
      ovfFlag_q   <= ovfFlag_d;
    end
  end

  // Operand2 is stored already inverted for subtract, so the flags use the effective operand.
  always_comb begin
    state_d     = state_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    sum_d       = sum_q;
    byteIdx_d   = byteIdx_q;
    carry_d     = carry_q;
    carryFlag_d = carryFlag_q;
    ovfFlag_d   = ovfFlag_q;
    reqReady    = 1'b0;
    rspValid    = 1'b0;
    sliceOp1    = 8'h00;
    sliceOp2    = 8'h00;
    sliceCarry  = 1'b0;

    case (state_q)
      IDLE: begin
        reqReady = ~rst_i;
        if (bus.req_valid_i && reqReady) begin
          op1_d       = bus.operand1_i;
          op2_d       = bus.sub_i ? ~bus.operand2_i : bus.operand2_i;
          carry_d     = bus.sub_i | bus.carry_i;
          byteIdx_d   = '0;
          sum_d       = '0;
          carryFlag_d = 1'b0;
          ovfFlag_d   = 1'b0;
          state_d     = RUN;
        end
      end

      RUN: begin
        sliceOp1             = op1_q[bitBase +: 8];
        sliceOp2             = op2_q[bitBase +: 8];
        sliceCarry           = carry_q;
        sum_d[bitBase +: 8]  = slice_sum_i;
        carry_d              = slice_carry_i;
        // The top byte's sum is only visible on the slice this cycle, so the flags are latched now.
        if (byteIdx_q == LASTIDX) begin
          carryFlag_d = slice_carry_i;
          ovfFlag_d   = (op1_q[WIDTH-1] == op2_q[WIDTH-1]) &&
                        (slice_sum_i[7] != op1_q[WIDTH-1]);
          state_d     = DONE;
        end else begin
          byteIdx_d = byteIdx_q + IDXW'(1);
        end
      end

      DONE: begin
        rspValid = 1'b1;
        if (bus.rsp_ready_i) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.req_ready_o = reqReady;
  assign bus.rsp_valid_o = rspValid;
  assign bus.sum_o       = sum_q;
  assign bus.carry_o     = carryFlag_q;
  assign bus.overflow_o  = ovfFlag_q;
  assign slice_op1_o     = sliceOp1;
  assign slice_op2_o     = sliceOp2;
  assign slice_carry_o   = sliceCarry;
  assign busy_o          = (state_q != IDLE);

endmodule

// File: tb/tb_multiword_add_ctrl.sv
// Directed and random bench for multiword_add_ctrl with a behavioural 8-bit slice
// and a queue of expected results popped at each response handshake.
module tb_multiword_add_ctrl;
  localparam int WIDTH = 32;

  typedef struct packed {
    logic [31:0] sum;
    logic        carry;
    logic        ovf;
  } result_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] sliceOp1, sliceOp2, sliceSum;
  logic       sliceCarryIn, sliceCarryOut, busy;

  result_t expQ[$];
  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int lastAccept = 0;
  int prevAccept = 0;

  multiword_add_ctrl_if #(.WIDTH(WIDTH)) ifc();

  multiword_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .bus           (ifc.slave),
    .slice_op1_o   (sliceOp1),
    .slice_op2_o   (sliceOp2),
    .slice_carry_o (sliceCarryIn),
    .slice_sum_i   (sliceSum),
    .slice_carry_i (sliceCarryOut),
    .busy_o        (busy)
  );

  // The external slice is modelled as an ideal 8-bit adder with carry in/out.
  assign {sliceCarryOut, sliceSum} = {1'b0, sliceOp1} + {1'b0, sliceOp2} + {8'd0, sliceCarryIn};

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before 500000");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic result_t refModel(input logic [31:0] a, input logic [31:0] b,
                                       input logic sub, input logic cin);
    logic [31:0] b2;
    logic [32:0] full;
    result_t     r;
    b2      = sub ? ~b : b;
    full    = {1'b0, a} + {1'b0, b2} + {32'd0, sub | cin};
    r.sum   = full[31:0];
    r.carry = full[32];
    r.ovf   = (a[31] == b2[31]) && (r.sum[31] != a[31]);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input logic sub, input logic cin, input result_t exp);
    int waited = 0;
    ifc.operand1_i  = a;
    ifc.operand2_i  = b;
    ifc.sub_i       = sub;
    ifc.carry_i     = cin;
    ifc.req_valid_i = 1'b1;
    while (ifc.req_ready_o !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    if (ifc.req_ready_o !== 1'b1) begin
      compared++;
      mismatched++;
      $error("[TB] FAIL accept_timeout: observed req_ready_o=%b expected 1 within 20 cycles",
             ifc.req_ready_o);
    end else begin
      prevAccept = lastAccept;
      lastAccept = cyc;
      expQ.push_back(exp);
      tick();
    end
    ifc.req_valid_i = 1'b0;
  endtask

  task automatic checkOutput(input int expLatency);
    int      waited = 0;
    result_t e;
    while (ifc.rsp_valid_o !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    if (ifc.rsp_valid_o !== 1'b1) begin
      compared++;
      mismatched++;
      $error("[TB] FAIL rsp_timeout: observed rsp_valid_o=%b expected 1 within 20 cycles",
             ifc.rsp_valid_o);
      return;
    end
    if (expLatency > 0) check("latency", 32'(cyc - lastAccept), 32'(expLatency));
    if (expQ.size() == 0) begin
      compared++;
      mismatched++;
      $error("[TB] FAIL unexpected_rsp: observed response sum 0x%0h expected none", ifc.sum_o);
    end else begin
      e = expQ.pop_front();
      check("sum", ifc.sum_o, e.sum);
      check("carry", 32'(ifc.carry_o), 32'(e.carry));
      check("overflow", 32'(ifc.overflow_o), 32'(e.ovf));
    end
    ifc.rsp_ready_i = 1'b1;
    tick();
  endtask

  initial begin
    result_t e;
    int      waited;
    logic [31:0] a, b;
    logic        sub, cin;

    ifc.req_valid_i = 1'b0;
    ifc.operand1_i  = '0;
    ifc.operand2_i  = '0;
    ifc.sub_i       = 1'b0;
    ifc.carry_i     = 1'b0;
    ifc.rsp_ready_i = 1'b1;

    // Reset state
    tick();
    tick();
    check("rst_req_ready", 32'(ifc.req_ready_o), 32'd0);
    check("rst_rsp_valid", 32'(ifc.rsp_valid_o), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sum", ifc.sum_o, 32'd0);
    check("rst_slice_op1", 32'(sliceOp1), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_req_ready", 32'(ifc.req_ready_o), 32'd1);

    // Byte carry ripple and response latency
    applyStimulus(32'h000000FF, 32'h00000001, 1'b0, 1'b0, '{32'h00000100, 1'b0, 1'b0});
    check("run_busy", 32'(busy), 32'd1);
    check("run_req_ready", 32'(ifc.req_ready_o), 32'd0);
    check("b0_slice_op1", 32'(sliceOp1), 32'h000000FF);
    check("b0_slice_op2", 32'(sliceOp2), 32'h00000001);
    check("b0_slice_carry", 32'(sliceCarryIn), 32'd0);
    tick();
    check("b1_slice_carry", 32'(sliceCarryIn), 32'd1);
    check("b1_slice_op1", 32'(sliceOp1), 32'd0);
    checkOutput(5);

    applyStimulus(32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1, '{32'h00000000, 1'b1, 1'b0});
    checkOutput(5);
    applyStimulus(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, '{32'h80000000, 1'b0, 1'b1});
    checkOutput(5);

    // Subtract: inverted operand2 and forced carry-in on the slice
    applyStimulus(32'd5, 32'd7, 1'b1, 1'b1, '{32'hFFFFFFFE, 1'b0, 1'b0});
    check("sub_slice_op2", 32'(sliceOp2), 32'h000000F8);
    check("sub_slice_carry", 32'(sliceCarryIn), 32'd1);
    checkOutput(5);
    applyStimulus(32'd7, 32'd5, 1'b1, 1'b0, '{32'h00000002, 1'b1, 1'b0});
    checkOutput(5);
    applyStimulus(32'h80000000, 32'd1, 1'b1, 1'b0, '{32'h7FFFFFFF, 1'b1, 1'b1});
    checkOutput(5);

    // Backpressure in DONE with a competing request held valid
    ifc.rsp_ready_i = 1'b0;
    applyStimulus(32'h12345678, 32'h11111111, 1'b0, 1'b0, '{32'h23456789, 1'b0, 1'b0});
    waited = 0;
    while (ifc.rsp_valid_o !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    check("bp_rsp_valid_rise", 32'(ifc.rsp_valid_o), 32'd1);
    for (int i = 0; i < 3; i++) begin
      ifc.req_valid_i = 1'b1;
      ifc.operand1_i  = $urandom;
      ifc.operand2_i  = $urandom;
      ifc.sub_i       = 1'b1;
      check("bp_sum", ifc.sum_o, 32'h23456789);
      check("bp_rsp_valid", 32'(ifc.rsp_valid_o), 32'd1);
      check("bp_busy", 32'(busy), 32'd1);
      check("bp_req_ready", 32'(ifc.req_ready_o), 32'd0);
      tick();
    end
    checkOutput(0);
    check("post_hs_req_ready", 32'(ifc.req_ready_o), 32'd1);
    check("post_hs_busy", 32'(busy), 32'd0);
    applyStimulus(32'h00001000, 32'h00000234, 1'b1, 1'b0, '{32'h00000DCC, 1'b1, 1'b0});
    check("post_hs_accept", 32'(lastAccept), 32'(cyc - 1));
    checkOutput(5);

    // Reset at byte index 2 discards the in-flight request
    applyStimulus(32'hA5A5A5A5, 32'h5A5A5A5A, 1'b0, 1'b1, '{32'h00000000, 1'b1, 1'b0});
    tick();
    tick();
    check("b2_slice_op1", 32'(sliceOp1), 32'h000000A5);
    rst = 1'b1;
    #1;
    check("rst_gate_req_ready", 32'(ifc.req_ready_o), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    void'(expQ.pop_back());
    check("mid_rst_rsp_valid", 32'(ifc.rsp_valid_o), 32'd0);
    check("mid_rst_sum", ifc.sum_o, 32'd0);
    check("mid_rst_carry", 32'(ifc.carry_o), 32'd0);
    check("mid_rst_slice_op1", 32'(sliceOp1), 32'd0);
    check("mid_rst_slice_op2", 32'(sliceOp2), 32'd0);
    check("mid_rst_slice_carry", 32'(sliceCarryIn), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_req_ready", 32'(ifc.req_ready_o), 32'd1);
    for (int i = 0; i < 8; i++) begin
      check("no_rsp_after_rst", 32'(ifc.rsp_valid_o), 32'd0);
      tick();
    end
    applyStimulus(32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, '{32'h00010000, 1'b0, 1'b0});
    checkOutput(5);

    // Back-to-back random vectors with the consumer always ready
    ifc.rsp_ready_i = 1'b1;
    for (int i = 0; i < 100; i++) begin
      a   = $urandom;
      b   = $urandom;
      sub = 1'($urandom_range(0, 1));
      cin = 1'($urandom_range(0, 1));
      if (i % 10 == 0) a = {1'b0, 31'h7FFFFFFF};
      if (i % 10 == 1) b = 32'h80000000;
      applyStimulus(a, b, sub, cin, refModel(a, b, sub, cin));
      if (i > 0) check("spacing", 32'(lastAccept - prevAccept), 32'd6);
      checkOutput(5);
    end

    check("queue_empty", 32'(expQ.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/multiword_add_ctrl.md
# multiword_add_ctrl

Sequencer that computes WIDTH-bit add/subtract by time-sharing one external 8-bit prefix-adder slice (pre-processing, prefix tree and sum stage), one byte per cycle, LSB byte first, with ripple of the carry through a register. It sits between a requester using a valid/ready request channel and a consumer using a valid/ready response channel. It owns all sequencing, carry chaining, operand inversion for subtract, and flag generation. The slice stays purely combinational.

## Interface
- WIDTH, 32, operand/result width; multiple of 8, ≥ 8; NBYTES = WIDTH/8
- clk_i  in  1  clock; single clock domain, all logic rising-edge
- rst_i  in  1  synchronous, active-high reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when both high
- operand1_i  in  WIDTH  first operand
- operand2_i  in  WIDTH  second operand
- sub_i  in  1  1 = operand1 − operand2, 0 = add
- carry_i  in  1  carry-in for add; ignored when sub_i=1
- slice_op1_o  out  8  byte of operand1 to slice
- slice_op2_o  out  8  byte of effective operand2 (inverted if sub) to slice
- slice_carry_o  out  1  carry-in to slice
- slice_sum_i  in  8  slice sum, same cycle
- slice_carry_i  in  1  slice carry-out, same cycle
- rsp_valid_o  out  1  result valid
- rsp_ready_i  in  1  consumer ready
- sum_o  out  WIDTH  result
- carry_o  out  1  final carry-out (sub: 1 = no borrow)
- overflow_o  out  1  two's-complement overflow
- busy_o  out  1  high in RUN or DONE

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i & req_ready_o, latch operand1_i and op2eff = sub_i ? ~operand2_i : operand2_i.
  - Set carry register = sub_i ? 1 : carry_i, byte index = 0, clear result register, go to RUN.
- RUN, byte index k:
  - slice_op1_o = op1[8k+7:8k], slice_op2_o = op2eff[8k+7:8k], slice_carry_o = carry register.
  - At clock edge: result[8k+7:8k] ← slice_sum_i, carry register ← slice_carry_i, k ← k+1.
  - When k = NBYTES−1, go to DONE instead of incrementing.
- DONE:
  - rsp_valid_o=1; sum_o, carry_o and overflow_o held stable.
  - On rsp_ready_i, go to IDLE.
- Flags:
  - carry_o = final carry register.
  - overflow_o = (op1[MSB] == op2eff[MSB]) & (sum[MSB] != op1[MSB]).
- Outside RUN, slice_* outputs are driven to 0.
- sum_o, carry_o and overflow_o keep the last result until the next request is accepted. They are cleared at acceptance.
- req_valid_i is ignored outside IDLE, and operand changes after acceptance have no effect.
- Width arithmetic is modulo 2^WIDTH. No per-byte flags are exposed.

## Timing
- Reset (rst_i high at an edge) applies in any state, including mid-RUN:
  - Next state IDLE, byte index 0, carry register 0.
  - sum_o=0, carry_o=0, overflow_o=0, rsp_valid_o=0, busy_o=0, slice_* = 0.
  - req_ready_o is gated to 0 while rst_i is high and is 1 in the first cycle after.
  - An in-flight operation is discarded and no response is produced.
- Accept at edge T; RUN occupies cycles T+1 … T+NBYTES. rsp_valid_o is first high in cycle T+NBYTES+1 (5 cycles for WIDTH=32).
- Response handshake at edge R puts IDLE in cycle R+1. Minimum request-to-request spacing is NBYTES+2 cycles; no overlap.
- rsp_valid_o, once high, stays high until the handshake. Result outputs do not change while rsp_valid_o=1.
- The slice path is combinational in one cycle: slice_* outputs → slice_sum_i/slice_carry_i → registers.

## Test plan
(WIDTH=32, slice modelled as a correct 8-bit adder.)
- Add 0x000000FF + 0x00000001, carry_i=0 → sum_o=0x00000100, carry_o=0, overflow_o=0; rsp_valid_o rises exactly 5 cycles after accept; slice_carry_o=1 in RUN byte 1.
- Add 0xFFFFFFFF + 0x00000000, carry_i=1 → sum_o=0x00000000, carry_o=1, overflow_o=0. Then 0x7FFFFFFF + 0x00000001 → 0x80000000, carry_o=0, overflow_o=1.
- Sub 5 − 7 (carry_i=1, ignored) → 0xFFFFFFFE, carry_o=0, overflow_o=0. Sub 7 − 5 → 0x00000002, carry_o=1. Sub 0x80000000 − 1 → 0x7FFFFFFF, overflow_o=1.
- Backpressure:
  - Hold rsp_ready_i=0 for 3 cycles in DONE → outputs stable, busy_o=1, req_ready_o=0.
  - req_valid_i held high with changing operands is not accepted.
  - After the handshake, the next request is accepted in cycle R+1.
- Reset in RUN at byte index 2 → next cycle IDLE, rsp_valid_o=0, sum_o=0, slice_* =0. No response ever appears for that request; a new request then completes correctly.
- Back-to-back requests with rsp_ready_i tied 1 → accepts spaced exactly 6 cycles apart; 100 random add/sub vectors match a reference model for sum, carry and overflow.
